// File: rtl/register_file_32x64.sv
// 32-entry register file with one write port and two combinational read ports.
// Index 31 is hardwired to zero; optional same-cycle write-to-read forwarding.
module register_file_32x64 #(
  parameter int unsigned WIDTH  = 64,
  parameter bit          BYPASS = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             RegWrite,
  input  logic [4:0]       WriteRegister,
  input  logic [WIDTH-1:0] WriteData,
  input  logic [4:0]       ReadRegister1,
  input  logic [4:0]       ReadRegister2,
  output logic [WIDTH-1:0] ReadData1,
  output logic [WIDTH-1:0] ReadData2
);

  localparam int unsigned NREGS = 32;
  localparam int unsigned AW    = 5;
  localparam logic [AW-1:0] ZERO_IDX = AW'(31);

  logic [WIDTH-1:0] regs [NREGS];
  logic [NREGS-1:0] wen_c;
  logic             fwd1_c;
  logic             fwd2_c;

  // One-hot write enable; index 31 never gets one, so it stays at its reset value
  always_comb begin
    wen_c = '0;
    if (RegWrite && (WriteRegister != ZERO_IDX)) begin
      wen_c[WriteRegister] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        if (wen_c[i]) begin
          regs[i] <= WriteData;
        end
      end
    end
  end

  // Forwarding is suppressed during reset because the write is about to be discarded
  always_comb begin
    fwd1_c = BYPASS && !reset && wen_c[ReadRegister1];
    fwd2_c = BYPASS && !reset && wen_c[ReadRegister2];
  end

  always_comb begin
    ReadData1 = regs[ReadRegister1];
    ReadData2 = regs[ReadRegister2];
    if (fwd1_c) begin
      ReadData1 = WriteData;
    end
    if (fwd2_c) begin
      ReadData2 = WriteData;
    end
    if (ReadRegister1 == ZERO_IDX) begin
      ReadData1 = '0;
    end
    if (ReadRegister2 == ZERO_IDX) begin
      ReadData2 = '0;
    end
  end

endmodule

// File: tb/tb_register_file_32x64.sv
// Self-checking bench: forwarding and non-forwarding instances driven in parallel,
// compared against an array-based reference model plus directed scenarios.
module tb_register_file_32x64;

  localparam int unsigned WIDTH = 64;

  logic             clk;
  logic             reset;
  logic             reg_write;
  logic [4:0]       wr_idx;
  logic [WIDTH-1:0] wr_data;
  logic [4:0]       rd_idx1;
  logic [4:0]       rd_idx2;
  logic [WIDTH-1:0] rd_byp1, rd_byp2;
  logic [WIDTH-1:0] rd_nb1, rd_nb2;

  int checks = 0;
  int errors = 0;

  logic [WIDTH-1:0] model [32];

  register_file_32x64 #(.WIDTH(WIDTH), .BYPASS(1'b1)) dut (
    .clk(clk), .reset(reset), .RegWrite(reg_write), .WriteRegister(wr_idx),
    .WriteData(wr_data), .ReadRegister1(rd_idx1), .ReadRegister2(rd_idx2),
    .ReadData1(rd_byp1), .ReadData2(rd_byp2)
  );

  register_file_32x64 #(.WIDTH(WIDTH), .BYPASS(1'b0)) dut_nb (
    .clk(clk), .reset(reset), .RegWrite(reg_write), .WriteRegister(wr_idx),
    .WriteData(wr_data), .ReadRegister1(rd_idx1), .ReadRegister2(rd_idx2),
    .ReadData1(rd_nb1), .ReadData2(rd_nb2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [WIDTH-1:0] got, input logic [WIDTH-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Expected read value from the architectural rules
  function automatic logic [WIDTH-1:0] expect_read(input bit byp, input logic [4:0] idx);
    if (idx == 5'd31) return '0;
    if (byp && !reset && reg_write && (wr_idx == idx)) return wr_data;
    return model[idx];
  endfunction

  // Drive one cycle (inputs set after negedge), check mid-cycle, then clock the model
  task automatic cyc(input bit rst, input bit we, input logic [4:0] wi, input logic [WIDTH-1:0] wd,
                     input logic [4:0] r1, input logic [4:0] r2);
    reset = rst; reg_write = we; wr_idx = wi; wr_data = wd; rd_idx1 = r1; rd_idx2 = r2;
    #1;
    check("byp_rd1", rd_byp1, expect_read(1'b1, r1));
    check("byp_rd2", rd_byp2, expect_read(1'b1, r2));
    check("nb_rd1",  rd_nb1,  expect_read(1'b0, r1));
    check("nb_rd2",  rd_nb2,  expect_read(1'b0, r2));
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < 32; i++) model[i] = '0;
    end else if (we && wi != 5'd31) begin
      model[wi] = wd;
    end
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) model[i] = '0;
    reset = 1'b1; reg_write = 1'b1; wr_idx = 5'd3; wr_data = '1; rd_idx1 = '0; rd_idx2 = '0;
    @(posedge clk);
    @(negedge clk);

    // Every index reads zero after reset
    for (int i = 0; i < 32; i++) cyc(1'b0, 1'b0, 5'd0, '0, 5'(i), 5'(31 - i));

    // Basic write then read on both ports, neighbours untouched
    cyc(1'b0, 1'b1, 5'd5, 64'h0123_4567_89AB_CDEF, 5'd0, 5'd1);
    rd_idx1 = 5'd5; rd_idx2 = 5'd5; reg_write = 1'b0; #1;
    check("x5_port1", rd_byp1, 64'h0123_4567_89AB_CDEF);
    check("x5_port2", rd_nb2, 64'h0123_4567_89AB_CDEF);
    cyc(1'b0, 1'b0, 5'd0, '0, 5'd5, 5'd5);
    cyc(1'b0, 1'b0, 5'd0, '0, 5'd4, 5'd6);

    // Hardwired zero register, including during the write cycle
    cyc(1'b0, 1'b1, 5'd31, '1, 5'd31, 5'd31);
    cyc(1'b0, 1'b0, 5'd0, '0, 5'd31, 5'd31);

    // Forwarding versus old data during a same-cycle write
    cyc(1'b0, 1'b1, 5'd7, 64'hAA, 5'd0, 5'd0);
    reset = 1'b0; reg_write = 1'b1; wr_idx = 5'd7; wr_data = 64'h55; rd_idx1 = 5'd7; rd_idx2 = 5'd7; #1;
    check("fwd_new", rd_byp1, 64'h55);
    check("nofwd_old", rd_nb1, 64'hAA);
    cyc(1'b0, 1'b1, 5'd7, 64'h55, 5'd7, 5'd7);
    cyc(1'b0, 1'b0, 5'd0, '0, 5'd7, 5'd7);
    check("nofwd_after", rd_nb1, 64'h55);

    // Reset beats a concurrent write and suppresses forwarding
    cyc(1'b0, 1'b1, 5'd10, 64'h1234, 5'd0, 5'd0);
    cyc(1'b1, 1'b1, 5'd10, 64'h9999, 5'd10, 5'd10);
    cyc(1'b0, 1'b0, 5'd10, 64'h7777, 5'd10, 5'd10);
    check("x10_after_reset", rd_byp1, '0);

    // Fill all writable registers, then a disabled write must not land
    for (int k = 0; k < 31; k++) cyc(1'b0, 1'b1, 5'(k), 64'(k * 'h1111), 5'(k), 5'd31);
    cyc(1'b0, 1'b0, 5'd3, 64'hDEAD, 5'd3, 5'd3);
    for (int k = 0; k < 32; k++) cyc(1'b0, 1'b0, 5'($urandom_range(0, 31)), '1, 5'(k), 5'(k));
    rd_idx1 = 5'd3; rd_idx2 = 5'd30; #1;
    check("x3_kept", rd_nb1, 64'h3333);
    check("x30_fill", rd_byp2, 64'(30 * 'h1111));

    // Randomized traffic, biased toward address collisions
    for (int n = 0; n < 500; n++) begin
      logic [4:0] wi, r1, r2;
      wi = 5'($urandom_range(0, 31));
      r1 = ($urandom_range(0, 3) == 0) ? wi : 5'($urandom_range(0, 31));
      r2 = ($urandom_range(0, 3) == 0) ? r1 : 5'($urandom_range(0, 31));
      cyc(($urandom_range(0, 40) == 0), ($urandom_range(0, 1) == 1), wi,
          {$urandom, $urandom}, r1, r2);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
